nr_mod_mapper: RTL and testbench

//  Streaming constellation mapper for the PUCCH transmit chain: takes packed coded bits
//  on a valid/ready word interface and emits one sfix16 complex symbol per cycle.

---
 rtl/nr_mod_mapper.sv | 131 +++++++++++++
 tb/tb_nr_mod_mapper.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nr_mod_mapper.sv
// Streaming BPSK / pi/2-BPSK / QPSK constellation mapper, packed bits in, Q1.15 IQ out.
// Optional macro NR_MOD_MAPPER_SYMIDX_EN adds the o_sym_idx output and a full-width symbol index.
module nr_mod_mapper #(
  parameter int IN_W  = 8,
  parameter int AMP   = 23170,
  parameter int CNT_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IN_W-1:0]   i_data,
  input  logic [1:0]        i_mode,
  input  logic              i_last,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [15:0]       o_re,
  output logic [15:0]       o_im,
  output logic              o_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_err
`ifdef NR_MOD_MAPPER_SYMIDX_EN
  ,
  output logic [CNT_W-1:0]  o_sym_idx
`endif
);

  // Handshake: a word moves when i_valid & o_ready on a rising edge, a symbol moves when
  // o_valid & i_ready; o_valid and the payload stay frozen while o_valid & !i_ready.

  localparam int BC_W = $clog2(IN_W + 1);
`ifdef NR_MOD_MAPPER_SYMIDX_EN
  localparam int IDX_W = CNT_W;
`else
  localparam int IDX_W = 1;
`endif

  localparam logic [15:0]     POS       = 16'(AMP);
  localparam logic [15:0]     NEG       = 16'(-AMP);
  localparam logic [1:0]      M_PI2     = 2'd1;
  localparam logic [1:0]      M_QPSK    = 2'd2;
  localparam logic [1:0]      M_RSVD    = 2'd3;
  localparam logic [BC_W-1:0] SYM_FULL  = BC_W'(IN_W);
  localparam logic [BC_W-1:0] SYM_HALF  = BC_W'(IN_W / 2);

  logic [IN_W-1:0]  buf_q;
  logic [BC_W-1:0]  buf_cnt;
  logic [1:0]       buf_mode;
  logic             buf_last;
  logic [IDX_W-1:0] idx;

  logic             out_load, buf_empty, accept, in_rsvd, emit, load_full;
  logic             src_ok, src_last, src_qpsk, sym_last, b_re, b_im;
  logic [BC_W-1:0]  in_cnt, src_cnt;
  logic [1:0]       src_mode;
  logic [IN_W-1:0]  src_data, src_shift;

  // An empty buffer lets the incoming word feed the output register directly, so the
  // first symbol appears the cycle after the accept.
  always_comb begin
    out_load  = !o_valid || i_ready;
    buf_empty = (buf_cnt == '0);
    o_ready   = buf_empty || ((buf_cnt == BC_W'(1)) && out_load);
    accept    = i_valid && o_ready;
    in_rsvd   = (i_mode == M_RSVD);
    in_cnt    = (i_mode == M_QPSK) ? SYM_HALF : SYM_FULL;
    src_data  = buf_empty ? i_data : buf_q;
    src_mode  = buf_empty ? i_mode : buf_mode;
    src_last  = buf_empty ? i_last : buf_last;
    src_cnt   = buf_empty ? in_cnt : buf_cnt;
    src_ok    = buf_empty ? (accept && !in_rsvd) : 1'b1;
    emit      = out_load && src_ok;
    load_full = accept && (!buf_empty || !emit);
    src_qpsk  = (src_mode == M_QPSK);
    b_re      = src_data[0] ^ ((src_mode == M_PI2) && idx[0]);
    b_im      = src_qpsk ? src_data[1] : src_data[0];
    sym_last  = src_last && (src_cnt == BC_W'(1));
    src_shift = src_qpsk ? (src_data >> 2) : (src_data >> 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_q    <= '0;
      buf_cnt  <= '0;
      buf_mode <= '0;
      buf_last <= 1'b0;
      idx      <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_re     <= '0;
      o_im     <= '0;
      o_err    <= 1'b0;
`ifdef NR_MOD_MAPPER_SYMIDX_EN
      o_sym_idx <= '0;
`endif
    end else begin
      o_err <= accept && in_rsvd;

      if (load_full) begin
        buf_q    <= i_data;
        buf_cnt  <= in_rsvd ? '0 : in_cnt;
        buf_mode <= i_mode;
        buf_last <= i_last;
      end else if (emit) begin
        buf_q    <= src_shift;
        buf_cnt  <= src_cnt - BC_W'(1);
        buf_mode <= src_mode;
        buf_last <= src_last;
      end

      // A reserved last word closes the frame after everything buffered ahead of it.
      if (accept && in_rsvd && i_last) begin
        idx <= '0;
      end else if (emit) begin
        idx <= sym_last ? '0 : idx + IDX_W'(1);
      end

      if (out_load) begin
        o_valid <= emit;
        o_last  <= emit && sym_last;
        if (emit) begin
          o_re <= b_re ? NEG : POS;
          o_im <= b_im ? NEG : POS;
`ifdef NR_MOD_MAPPER_SYMIDX_EN
          o_sym_idx <= idx;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_nr_mod_mapper.sv
// Directed and randomised-backpressure bench for nr_mod_mapper (IN_W=8).
// Connects o_sym_idx when NR_MOD_MAPPER_SYMIDX_EN is defined.
module tb_nr_mod_mapper;

  localparam int          IN_W  = 8;
  localparam int          CNT_W = 12;
  localparam logic [15:0] P     = 16'h5A82;
  localparam logic [15:0] N     = 16'hA57E;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [IN_W-1:0] i_data = '0;
  logic [1:0]      i_mode = '0;
  logic            i_last = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [15:0]     o_re, o_im;
  logic            o_last, o_valid;
  logic            i_ready = 1'b1;
  logic            o_err;
`ifdef NR_MOD_MAPPER_SYMIDX_EN
  logic [CNT_W-1:0] o_sym_idx;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  int          xfer_cyc[$];
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          err_cnt = 0;
  int          mdl_idx = 0;
  bit          bp_en = 1'b0;
  bit          ready_force = 1'b1;

  nr_mod_mapper #(.IN_W(IN_W), .AMP(23170), .CNT_W(CNT_W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .i_last  (i_last),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_re    (o_re),
    .o_im    (o_im),
    .o_last  (o_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_err   (o_err)
`ifdef NR_MOD_MAPPER_SYMIDX_EN
    ,
    .o_sym_idx (o_sym_idx)
`endif
  );

  // clock / cycle counter / downstream ready
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(posedge i_clk) begin
    #2;
    i_ready = bp_en ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor: sampled on the falling edge, away from the active edge
  logic        stall_q = 1'b0;
  logic [32:0] held = '0;
  always @(negedge i_clk) begin
    logic [32:0] exp_sym;
    if (o_err) err_cnt++;
    if (i_rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("stable", {o_valid, o_last, o_re, o_im}, {1'b1, held});
      if (o_valid && i_ready) begin
        xfer_cnt++;
        xfer_cyc.push_back(cyc);
        exp_sym = (exp_q.size() != 0) ? exp_q.pop_front() : 33'bx;
        check("sym", {o_last, o_re, o_im}, exp_sym);
      end
      stall_q = o_valid && !i_ready;
      held    = {o_last, o_re, o_im};
    end
  end

  task automatic push_sym(input logic l, input logic [15:0] re, input logic [15:0] im);
    exp_q.push_back({l, re, im});
  endtask

  // reference mapping used for the random traffic
  task automatic model_word(input logic [IN_W-1:0] d, input logic [1:0] m, input logic l);
    int n;
    logic [IN_W-1:0] s;
    logic [15:0] re, im;
    logic lst;
    if (m == 2'd3) begin
      if (l) mdl_idx = 0;
      return;
    end
    n = (m == 2'd2) ? IN_W / 2 : IN_W;
    s = d;
    for (int k = 0; k < n; k++) begin
      re = s[0] ? N : P;
      im = (m == 2'd2) ? (s[1] ? N : P) : re;
      s  = (m == 2'd2) ? (s >> 2) : (s >> 1);
      if (m == 2'd1 && (mdl_idx % 2) == 1) re = (re == P) ? N : P;
      lst = l && (k == n - 1);
      push_sym(lst, re, im);
      mdl_idx = lst ? 0 : (mdl_idx + 1) % (1 << CNT_W);
    end
  endtask

  // driver: call at posedge+1; returns the cycle number of the accepting edge
  task automatic send_word(input logic [IN_W-1:0] d, input logic [1:0] m, input logic l,
                           output int acc);
    bit got = 1'b0;
    bit rdy;
    i_data  = d;
    i_mode  = m;
    i_last  = l;
    i_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge i_clk);
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      if (rdy) got = 1'b1;
    end
    i_valid = 1'b0;
    acc = cyc;
    check("accept", got, 1'b1);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge i_clk);
    repeat (3) @(posedge i_clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int a1, a2, a3, xb, eb, np;
    bit hit;
    logic [15:0] t1[8];
    logic [15:0] t2[8];
    logic [IN_W-1:0] d;
    logic [1:0] m;
    logic l;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid", o_valid, 1'b0);
    check("rst_ready", o_ready, 1'b1);
    check("rst_err",   o_err,   1'b0);
    check("rst_last",  o_last,  1'b0);
    check("rst_re",    o_re,    16'h0);
    check("rst_im",    o_im,    16'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // BPSK 0x5A, bits LSB first: 0,1,0,1,1,0,1,0
    t1 = '{P, N, P, N, N, P, N, P};
    for (int k = 0; k < 8; k++) push_sym(k == 7, t1[k], t1[k]);
    xfer_cyc.delete();
    send_word(8'h5A, 2'd0, 1'b1, a1);
    drain();
    check("t1_latency", xfer_cyc[0], a1);

    // pi/2-BPSK all zeros, two frames; odd symbols rotate by j
    t2 = '{P, N, P, N, P, N, P, N};
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++) push_sym(k == 7, t2[k], P);
    send_word(8'h00, 2'd1, 1'b1, a1);
    send_word(8'h00, 2'd1, 1'b1, a1);
    drain();

    // QPSK 0xE4 three times back-to-back: pairs 00,01,10,11
    for (int w = 0; w < 3; w++) begin
      push_sym(1'b0, P, P);
      push_sym(1'b0, N, P);
      push_sym(1'b0, P, N);
      push_sym(w == 2, N, N);
    end
    xfer_cyc.delete();
    send_word(8'hE4, 2'd2, 1'b0, a1);
    send_word(8'hE4, 2'd2, 1'b0, a2);
    send_word(8'hE4, 2'd2, 1'b1, a3);
    drain();
    check("t3_latency", xfer_cyc[0], a1);
    check("t3_count", xfer_cyc.size(), 12);
    check("t3_no_bubble", xfer_cyc[11] - xfer_cyc[0], 11);
    check("t3_accept_gap", a3 - a2, 4);

    // reserved word between two BPSK words: 0x0F -> N,N,N,N,P,P,P,P ; 0x33 -> N,N,P,P,N,N,P,P
    eb = err_cnt;
    xb = xfer_cnt;
    for (int k = 0; k < 8; k++) push_sym(1'b0, (k < 4) ? N : P, (k < 4) ? N : P);
    for (int k = 0; k < 8; k++) push_sym(k == 7, k[1] ? P : N, k[1] ? P : N);
    send_word(8'h0F, 2'd0, 1'b0, a1);
    send_word(8'hFF, 2'd3, 1'b0, a1);
    send_word(8'h33, 2'd0, 1'b1, a1);
    drain();
    check("t5_err_pulses", err_cnt - eb, 1);
    check("t5_syms", xfer_cnt - xb, 16);

    // reset with the third pi/2 symbol stalled on the output
    xb = xfer_cnt;
    for (int k = 0; k < 8; k++) push_sym(k == 7, t2[k], P);
    send_word(8'h00, 2'd1, 1'b1, a1);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      if (xfer_cnt >= xb + 2) hit = 1'b1;
      else begin
        @(posedge i_clk);
        #1;
      end
    end
    check("t6_reach", hit, 1'b1);
    ready_force = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    check("t6_before_rst_xfers", xfer_cnt - xb, 2);
    @(negedge i_clk);
    check("t6_rst_valid", o_valid, 1'b0);
    check("t6_rst_ready", o_ready, 1'b1);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    ready_force = 1'b1;
    exp_q.delete();
    mdl_idx = 0;
    for (int k = 0; k < 8; k++) push_sym(k == 7, t2[k], P);
    send_word(8'h00, 2'd1, 1'b1, a1);
    drain();

    // random words and modes under random backpressure
    bp_en = 1'b1;
    xb = xfer_cnt;
    np = 0;
    for (int w = 0; w < 100; w++) begin
      d = IN_W'($urandom_range(0, 255));
      m = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 5) == 0);
      if (m != 2'd3) np += (m == 2'd2) ? IN_W / 2 : IN_W;
      model_word(d, m, l);
      send_word(d, m, l, a1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge i_clk);
        #1;
      end
    end
    drain();
    bp_en = 1'b0;
    check("t4_count", xfer_cnt - xb, np);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
